// File: rtl/wishbone_pkg.sv
// wishbone_pkg: shared types and address-map constants for the Wishbone router
// Contents:
//   wb_state_t   per-transaction FSM states (IDLE, ACTIVE, RESP)
//   *_BASE       upper address bits identifying each subordinate region
package wishbone_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} wb_state_t;

    localparam logic [15:0] LA_BASE   = 16'h3100;
    localparam logic [15:0] GPIO_BASE = 16'h3200;
    localparam logic [15:0] SRAM_BASE = 16'h3300;
    localparam logic [7:0]  PROJ_BASE = 8'h30;

endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: combinational address decoder, manager address -> subordinate index
// Ports:
//   adr_i     in   32      manager address
//   sel_o     out  SEL_W   subordinate index (projects 0..NUM_TEAMS, then LA, GPIO, SRAM)
//   mapped_o  out  1       address hits a mapped subordinate
module wb_addr_decode
    import wishbone_pkg::*;
#(
    parameter int NUM_TEAMS = 12,
    parameter int SEL_W     = $clog2(NUM_TEAMS + 4)
) (
    input  logic [31:0]      adr_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             mapped_o
);

    logic hit_la;
    logic hit_gpio;
    logic hit_sram;
    logic hit_proj;
    logic unused_adr;

    // Only the region bits take part in decoding; the offset is the subordinate's business.
    assign unused_adr = ^adr_i[15:0];

    assign hit_la   = adr_i[31:16] == LA_BASE;
    assign hit_gpio = adr_i[31:16] == GPIO_BASE;
    assign hit_sram = adr_i[31:16] == SRAM_BASE;
    // Projects above NUM_TEAMS fall into the 0x30 region but have no subordinate behind them.
    assign hit_proj = (adr_i[31:24] == PROJ_BASE) && ({28'd0, adr_i[19:16]} <= NUM_TEAMS);

    assign mapped_o = hit_la || hit_gpio || hit_sram || hit_proj;
    assign sel_o    = hit_la   ? SEL_W'(NUM_TEAMS + 1) :
                      hit_gpio ? SEL_W'(NUM_TEAMS + 2) :
                      hit_sram ? SEL_W'(NUM_TEAMS + 3) :
                                 SEL_W'(adr_i[19:16]);

endmodule

// File: rtl/wishbone_router.sv
// wishbone_router: single-manager Wishbone address router with bus-error and timeout responses
// Ports:
//   CLK, nRST        clock; asynchronous active-low reset
//   wbs_adr_i_p      manager address
//   wbs_cyc_i_p      manager cycle
//   wbs_stb_i_p      manager strobe
//   wbs_ack_o_p      registered one-cycle ack to manager
//   wbs_err_o_p      registered one-cycle error to manager
//   wbs_dat_o_p      registered read data to manager (only non-zero in the response cycle)
//   wbs_cyc_o_sub    per-subordinate cyc
//   wbs_stb_o_sub    per-subordinate stb
//   wbs_ack_i_sub    per-subordinate ack
//   wbs_dat_i_sub    per-subordinate read data, subordinate i at bits [i*32 +: 32]
module wishbone_router
    import wishbone_pkg::*;
#(
    parameter int          NUM_TEAMS      = 12,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0,
    localparam int         NUM_SUBS       = NUM_TEAMS + 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [31:0]           wbs_adr_i_p,
    input  logic                  wbs_cyc_i_p,
    input  logic                  wbs_stb_i_p,
    output logic                  wbs_ack_o_p,
    output logic                  wbs_err_o_p,
    output logic [31:0]           wbs_dat_o_p,
    output logic [NUM_SUBS-1:0]   wbs_cyc_o_sub,
    output logic [NUM_SUBS-1:0]   wbs_stb_o_sub,
    input  logic [NUM_SUBS-1:0]   wbs_ack_i_sub,
    input  logic [NUM_SUBS*32-1:0] wbs_dat_i_sub
);

    localparam int SEL_W = $clog2(NUM_SUBS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_t        state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      dat_q, dat_d;
    logic [SEL_W-1:0] dec_sel;
    logic             dec_mapped;
    logic [31:0]      sel_dat;

    wb_addr_decode #(
        .NUM_TEAMS (NUM_TEAMS),
        .SEL_W     (SEL_W)
    ) u_decode (
        .adr_i    (wbs_adr_i_p),
        .sel_o    (dec_sel),
        .mapped_o (dec_mapped)
    );

    assign sel_dat     = wbs_dat_i_sub[{sel_q, 5'd0} +: 32];
    assign wbs_ack_o_p = ack_q;
    assign wbs_err_o_p = err_q;
    assign wbs_dat_o_p = dat_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // ack/err/dat next values are only non-zero on the transition into RESP,
    // so the registered outputs are high for exactly the RESP cycle.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        dat_d         = '0;
        wbs_cyc_o_sub = '0;
        wbs_stb_o_sub = '0;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i_p && wbs_stb_i_p) begin
                    if (dec_mapped) begin
                        state_d = ACTIVE;
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        dat_d   = ERR_DATA;
                    end
                end
            end
            ACTIVE: begin
                wbs_cyc_o_sub[sel_q] = wbs_cyc_i_p;
                wbs_stb_o_sub[sel_q] = wbs_stb_i_p;
                cnt_d                = cnt_q + CNT_W'(1);
                // A manager abort ends the transaction silently, whatever the subordinate does.
                if (!wbs_cyc_i_p) begin
                    state_d = IDLE;
                end else if (wbs_ack_i_sub[sel_q]) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    dat_d   = sel_dat;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    dat_d   = ERR_DATA;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wishbone_router.sv
// tb_wishbone_router: directed vector bench for wishbone_router
module tb_wishbone_router;

    localparam int NT = 12;
    localparam int NS = NT + 4;
    localparam int TO = 8;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic [31:0]      adr = '0;
    logic             cyc = 1'b0;
    logic             stb = 1'b0;
    logic             ack_o;
    logic             err_o;
    logic [31:0]      dat_o;
    logic [NS-1:0]    cyc_sub;
    logic [NS-1:0]    stb_sub;
    logic [NS-1:0]    ack_sub = '0;
    logic [NS*32-1:0] dat_sub;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    wishbone_router #(
        .NUM_TEAMS      (NT),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (BAD)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .wbs_adr_i_p   (adr),
        .wbs_cyc_i_p   (cyc),
        .wbs_stb_i_p   (stb),
        .wbs_ack_o_p   (ack_o),
        .wbs_err_o_p   (err_o),
        .wbs_dat_o_p   (dat_o),
        .wbs_cyc_o_sub (cyc_sub),
        .wbs_stb_o_sub (stb_sub),
        .wbs_ack_i_sub (ack_sub),
        .wbs_dat_i_sub (dat_sub)
    );

    typedef struct {
        logic [31:0]   adr;
        logic          cyc;
        logic          stb;
        logic [NS-1:0] ack;
        logic          e_ack;
        logic          e_err;
        logic [31:0]   e_dat;
        logic [NS-1:0] e_cyc;
        logic [NS-1:0] e_stb;
    } vec_t;

    vec_t vt[25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic c, input logic s, input logic [NS-1:0] k);
        adr     = a;
        cyc     = c;
        stb     = s;
        ack_sub = k;
    endtask

    task automatic check_all(input string tag, input logic ea, input logic ee, input logic [31:0] ed,
                             input logic [NS-1:0] ec, input logic [NS-1:0] es);
        chk({tag, " ack"}, 32'(ack_o), 32'(ea));
        chk({tag, " err"}, 32'(err_o), 32'(ee));
        chk({tag, " dat"}, dat_o, ed);
        chk({tag, " cyc_sub"}, 32'(cyc_sub), 32'(ec));
        chk({tag, " stb_sub"}, 32'(stb_sub), 32'(es));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [NS-1:0] z;
        z = '0;
        for (int i = 0; i < NS; i++)
            dat_sub[i*32 +: 32] = (i == NT + 2) ? 32'hCAFE_0001 : 32'hA000_0000 + 32'(i);

        // cycle-by-cycle vectors; check taken mid-cycle after inputs settle
        // GPIO read, ack two cycles after request
        vt[0]  = '{32'h3200_0004, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          z,          z};
        vt[1]  = '{32'h3200_0004, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          16'h4000,   16'h4000};
        vt[2]  = '{32'h3200_0004, 1'b1, 1'b1, 16'h4000,   1'b0, 1'b0, 32'h0,          16'h4000,   16'h4000};
        vt[3]  = '{32'h0,         1'b0, 1'b0, z,          1'b1, 1'b0, 32'hCAFE_0001,  z,          z};
        vt[4]  = '{32'h0,         1'b0, 1'b0, z,          1'b0, 1'b0, 32'h0,          z,          z};
        // project 5, with a stray ack from project 3
        vt[5]  = '{32'h3005_0000, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          z,          z};
        vt[6]  = '{32'h3005_0000, 1'b1, 1'b1, 16'h0028,   1'b0, 1'b0, 32'h0,          16'h0020,   16'h0020};
        // back-to-back: next (unmapped) request already presented during RESP
        vt[7]  = '{32'h3400_0000, 1'b1, 1'b1, z,          1'b1, 1'b0, 32'hA000_0005,  z,          z};
        vt[8]  = '{32'h3400_0000, 1'b1, 1'b1, 16'hFFFF,   1'b0, 1'b0, 32'h0,          z,          z};
        vt[9]  = '{32'h0,         1'b0, 1'b0, z,          1'b0, 1'b1, BAD,            z,          z};
        // project 15 is beyond NUM_TEAMS
        vt[10] = '{32'h300F_0000, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          z,          z};
        vt[11] = '{32'h0,         1'b0, 1'b0, z,          1'b0, 1'b1, BAD,            z,          z};
        // project 12 is the highest mapped project
        vt[12] = '{32'h300C_0000, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          z,          z};
        vt[13] = '{32'h300C_0000, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          16'h1000,   16'h1000};
        vt[14] = '{32'h300C_0000, 1'b1, 1'b1, 16'h1000,   1'b0, 1'b0, 32'h0,          16'h1000,   16'h1000};
        vt[15] = '{32'h0,         1'b0, 1'b0, z,          1'b1, 1'b0, 32'hA000_000C,  z,          z};
        // SRAM request aborted by manager in ACTIVE cycle 2, late ack ignored
        vt[16] = '{32'h3300_0000, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          z,          z};
        vt[17] = '{32'h3300_0000, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          16'h8000,   16'h8000};
        vt[18] = '{32'h3300_0000, 1'b0, 1'b0, z,          1'b0, 1'b0, 32'h0,          z,          z};
        vt[19] = '{32'h0,         1'b0, 1'b0, 16'h8000,   1'b0, 1'b0, 32'h0,          z,          z};
        // LA request: address changes mid-ACTIVE, stb gap, non-selected ack
        vt[20] = '{32'h3100_0000, 1'b1, 1'b1, z,          1'b0, 1'b0, 32'h0,          z,          z};
        vt[21] = '{32'h3200_0000, 1'b1, 1'b0, 16'h4000,   1'b0, 1'b0, 32'h0,          16'h2000,   z};
        vt[22] = '{32'h3200_0000, 1'b1, 1'b1, 16'h2000,   1'b0, 1'b0, 32'h0,          16'h2000,   16'h2000};
        vt[23] = '{32'h0,         1'b0, 1'b0, z,          1'b1, 1'b0, 32'hA000_000D,  z,          z};
        vt[24] = '{32'h0,         1'b0, 1'b0, z,          1'b0, 1'b0, 32'h0,          z,          z};

        // reset state, with a request and acks presented during reset
        drive(32'h3200_0004, 1'b1, 1'b1, 16'hFFFF);
        next_cycle();
        next_cycle();
        #3;
        check_all("reset", 1'b0, 1'b0, 32'h0, z, z);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, z);
        nRST = 1'b1;

        for (int i = 0; i < 25; i++) begin
            next_cycle();
            drive(vt[i].adr, vt[i].cyc, vt[i].stb, vt[i].ack);
            #3;
            check_all($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_err, vt[i].e_dat, vt[i].e_cyc, vt[i].e_stb);
        end

        // SRAM never acks: err exactly once, 9 cycles after the request
        begin
            int n_err;
            n_err = 0;
            next_cycle();
            drive(32'h3300_0010, 1'b1, 1'b1, z);
            for (int c = 1; c <= 12; c++) begin
                next_cycle();
                if (c == 9) drive(32'h0, 1'b0, 1'b0, z);
                #3;
                if (err_o) n_err++;
                if (c <= 8) begin
                    chk($sformatf("timeout c%0d stb", c), 32'(stb_sub), 32'h8000);
                    chk($sformatf("timeout c%0d err", c), 32'(err_o), 32'h0);
                end else if (c == 9) begin
                    check_all("timeout resp", 1'b0, 1'b1, BAD, z, z);
                end
            end
            chk("timeout err count", 32'(n_err), 32'd1);
        end

        // ack arriving on the timeout cycle wins
        next_cycle();
        drive(32'h3300_0000, 1'b1, 1'b1, z);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            drive(32'h3300_0000, 1'b1, 1'b1, (c == 8) ? 16'h8000 : z);
        end
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, z);
        #3;
        check_all("ack at timeout", 1'b1, 1'b0, 32'hA000_000F, z, z);

        // reset asserted mid-ACTIVE
        next_cycle();
        next_cycle();
        drive(32'h3200_0000, 1'b1, 1'b1, z);
        next_cycle();
        #3;
        chk("pre-reset cyc_sub", 32'(cyc_sub), 32'h4000);
        nRST = 1'b0;
        #1;
        check_all("reset mid-ACTIVE", 1'b0, 1'b0, 32'h0, z, z);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, z);
        next_cycle();
        nRST = 1'b1;

        // first post-reset transaction
        next_cycle();
        drive(32'h3200_0008, 1'b1, 1'b1, z);
        next_cycle();
        next_cycle();
        drive(32'h3200_0008, 1'b1, 1'b1, 16'h4000);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, z);
        #3;
        check_all("post-reset", 1'b1, 1'b0, 32'hCAFE_0001, z, z);
        // reset during RESP clears the registered outputs at once
        nRST = 1'b0;
        #1;
        check_all("reset in RESP", 1'b0, 1'b0, 32'h0, z, z);
        next_cycle();
        nRST = 1'b1;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
